// File: rtl/full_subtractor_pkg.sv
// Shared definitions for the registered full subtractor.
// Holds the default operand width and the per-bit borrow equation.
package full_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 1;

  function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
    return (~a & b) | (~(a ^ b) & bin);
  endfunction

endpackage

// File: rtl/full_subtractor_fs_cell.sv
// Combinational 1-bit full subtractor cell: d = a - b - bin with borrow-out.
module fs_cell
  import full_subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = fs_borrow(a, b, bin);

endmodule

// File: rtl/full_subtractor.sv
// Registered WIDTH-bit subtract-with-borrow built from a ripple chain of fs_cell.
// One cycle of latency; D/Bout hold when no operands are accepted.
module full_subtractor
  import full_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             out_valid
);

  logic [WIDTH:0]   borrow_s;
  logic [WIDTH-1:0] diff_s;

  assign borrow_s[0] = Bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fs_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (borrow_s[i]),
      .d    (diff_s[i]),
      .bout (borrow_s[i+1])
    );
  end

  // Output registers: capture on accepted operands, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      D         <= '0;
      Bout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        D    <= diff_s;
        Bout <= borrow_s[WIDTH];
      end else begin
        D    <= D;
        Bout <= Bout;
      end
    end
  end

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench for full_subtractor at WIDTH=1 and WIDTH=8.
module tb_full_subtractor;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bout;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       bout;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid1, a1, b1, bin1, d1, bout1, ov1;
  logic       in_valid8, bin8, bout8, ov8;
  logic [7:0] a8, b8, d8;

  int checks = 0;
  int failures = 0;

  exp_t q1[$];
  exp_t q8[$];
  exp_t hold1, hold8;

  always #5 clk = ~clk;

  full_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .a(a1), .b(b1), .Bin(bin1),
    .D(d1), .Bout(bout1), .out_valid(ov1)
  );

  full_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .a(a8), .b(b8), .Bin(bin8),
    .D(d8), .Bout(bout8), .out_valid(ov8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One cycle on the 1-bit instance; expectations come from the caller.
  task automatic step1(input logic v, input logic a, input logic b, input logic bin,
                       input logic ed, input logic eb);
    exp_t e;
    logic rst_now;
    in_valid1 = v; a1 = a; b1 = b; bin1 = bin;
    rst_now = rst_n;
    if (v && rst_now) begin
      e.d = {7'd0, ed}; e.bout = eb;
      q1.push_back(e);
    end
    @(posedge clk); #1;
    if (!rst_now) begin
      chk("w1_rst_d", {31'd0, d1}, 32'd0);
      chk("w1_rst_bout", {31'd0, bout1}, 32'd0);
      chk("w1_rst_ov", {31'd0, ov1}, 32'd0);
      hold1 = '{8'd0, 1'b0};
      hold8 = '{8'd0, 1'b0};
    end else begin
      chk("w1_ov", {31'd0, ov1}, {31'd0, v});
      if (v) begin
        if (q1.size() == 0) begin
          chk("w1_queue_empty", 32'd1, 32'd0);
        end else begin
          hold1 = q1.pop_front();
        end
      end
      chk("w1_d", {31'd0, d1}, {31'd0, hold1.d[0]});
      chk("w1_bout", {31'd0, bout1}, {31'd0, hold1.bout});
    end
  endtask

  // One cycle on the 8-bit instance.
  task automatic step8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [7:0] ed, input logic eb);
    exp_t e;
    logic rst_now;
    in_valid8 = v; a8 = a; b8 = b; bin8 = bin;
    rst_now = rst_n;
    if (v && rst_now) begin
      e.d = ed; e.bout = eb;
      q8.push_back(e);
    end
    @(posedge clk); #1;
    if (!rst_now) begin
      chk("w8_rst_d", {24'd0, d8}, 32'd0);
      chk("w8_rst_bout", {31'd0, bout8}, 32'd0);
      chk("w8_rst_ov", {31'd0, ov8}, 32'd0);
      hold1 = '{8'd0, 1'b0};
      hold8 = '{8'd0, 1'b0};
    end else begin
      chk("w8_ov", {31'd0, ov8}, {31'd0, v});
      if (v) begin
        if (q8.size() == 0) begin
          chk("w8_queue_empty", 32'd1, 32'd0);
        end else begin
          hold8 = q8.pop_front();
        end
      end
      chk("w8_d", {24'd0, d8}, {24'd0, hold8.d});
      chk("w8_bout", {31'd0, bout8}, {31'd0, hold8.bout});
    end
  endtask

  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    exp_t r;
    logic [8:0] t;
    t = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    r.d = t[7:0];
    r.bout = ({1'b0, a} < ({1'b0, b} + {8'd0, bin}));
    return r;
  endfunction

  initial begin
    vec_t tt1[8];
    vec_t bnd8[4];
    exp_t m;
    logic [7:0] ra, rb;
    logic rbin, rv;

    tt1[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0};
    tt1[1] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b1};
    tt1[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b1};
    tt1[3] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1};
    tt1[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0};
    tt1[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b0};
    tt1[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b0};
    tt1[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1};

    bnd8[0] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    bnd8[1] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    bnd8[2] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0};
    bnd8[3] = '{8'h10, 8'h01, 1'b1, 8'h0E, 1'b0};

    hold1 = '{8'd0, 1'b0};
    hold8 = '{8'd0, 1'b0};
    in_valid8 = 1'b0; a8 = 8'd0; b8 = 8'd0; bin8 = 1'b0;

    // Reset held for two edges with valid operands present.
    rst_n = 1'b0;
    step1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // WIDTH=1 truth table, back-to-back.
    for (int i = 0; i < 8; i++) begin
      step1(1'b1, tt1[i].a[0], tt1[i].b[0], tt1[i].bin, tt1[i].d[0], tt1[i].bout);
    end

    // Hold: capture 1-1-1, then toggle inputs with in_valid low.
    step1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid1 = 1'b0;

    // WIDTH=8 boundaries.
    for (int i = 0; i < 4; i++) begin
      step8(1'b1, bnd8[i].a, bnd8[i].b, bnd8[i].bin, bnd8[i].d, bnd8[i].bout);
    end

    // Reset mid-stream: third edge of a back-to-back stream is under reset.
    m = model8(8'h33, 8'h44, 1'b0);
    step8(1'b1, 8'h33, 8'h44, 1'b0, m.d, m.bout);
    m = model8(8'h80, 8'h7F, 1'b1);
    step8(1'b1, 8'h80, 8'h7F, 1'b1, m.d, m.bout);
    rst_n = 1'b0;
    step8(1'b1, 8'hC0, 8'h01, 1'b0, 8'd0, 1'b0);
    rst_n = 1'b1;
    step8(1'b1, 8'h20, 8'h30, 1'b1, 8'hEF, 1'b1);

    // Random operands with random in_valid.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1));
      m = model8(ra, rb, rbin);
      step8(rv, ra, rb, rbin, m.d, m.bout);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/full_subtractor.md
Name: full_subtractor

Overview:
- Registered full subtractor: computes D = a − b − Bin with borrow-out Bout, one clock of latency.
- WIDTH=1 is the classic 1-bit full subtractor cell. Wider settings form a ripple-borrow chain of 1-bit cells.
- Used as an arithmetic leaf in datapaths needing subtract-with-borrow.
- Outputs are registered so the block drops into a pipelined path.

Parameters:
- WIDTH, 1, operand and difference width in bits (≥1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operands valid this cycle; captured only when 1
- a  input  WIDTH  minuend (unsigned)
- b  input  WIDTH  subtrahend (unsigned)
- Bin  input  1  borrow-in
- D  output  WIDTH  registered difference
- Bout  output  1  registered borrow-out
- out_valid  output  1  D/Bout hold a result captured on the previous accepted cycle

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). All state changes occur only on the rising edge of clk.
- Reset: on a rising edge with rst_n=0, D=0, Bout=0, out_valid=0. Reset overrides in_valid. Reset asserted mid-stream discards any in-flight result.
- Arithmetic (combinational, per bit i, with borrow chain c0=Bin):
  - d_i = a_i ^ b_i ^ c_i
  - c_{i+1} = (~a_i & b_i) | (~(a_i ^ b_i) & c_i)
  - Bout = c_WIDTH
- Equivalent unsigned form: {Bout, D} = (2^WIDTH + a − b − Bin) with Bout inverted. That is, D = (a − b − Bin) mod 2^WIDTH, and Bout = 1 iff a < b + Bin.
- Capture: on a rising edge with rst_n=1 and in_valid=1, D and Bout load the combinational result of the current a, b, Bin.
- Hold: with in_valid=0, D and Bout hold their previous values.
- out_valid: registered copy of in_valid (out_valid <= in_valid each non-reset edge).
- Latency: exactly 1 cycle from accepted inputs to D/Bout/out_valid.
- Throughput: one operation per cycle; back-to-back in_valid is supported.
- Boundaries:
  - a=b, Bin=0 → D=0, Bout=0.
  - a=0, b=all-ones, Bin=1 → D=0, Bout=1 (full wrap).
  - a=all-ones, b=0, Bin=0 → D=all-ones, Bout=0.
- No X propagation from Bin when unused: Bin always participates in the arithmetic.

Decomposition:
- No shared package needed. WIDTH is local.
- One natural sub-module: fs_cell, a combinational 1-bit full subtractor (a, b, bin → d, bout).
- Instantiate fs_cell WIDTH times in a generate loop, chaining bout to the next cell's bin.
- The top level adds the output registers and the valid pipeline.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with in_valid=1, a=1, b=0, Bin=0. Expect D=0, Bout=0, out_valid=0 throughout. Release; the next edge yields D=1, Bout=0, out_valid=1.
- WIDTH=1 exhaustive truth table, one vector per cycle with in_valid=1. Inputs (a,b,Bin) 000..111 in order must give (D,Bout) one cycle later: 00, 11, 11, 01, 10, 00, 00, 11.
- Hold: after capturing a=1, b=1, Bin=1 (D=1, Bout=1), drop in_valid and toggle the inputs for 3 cycles. Expect D=1, Bout=1 unchanged and out_valid=0.
- WIDTH=8 boundaries:
  - a=0x00, b=0xFF, Bin=1 → D=0x00, Bout=1.
  - a=0xFF, b=0x00, Bin=0 → D=0xFF, Bout=0.
  - a=0x5A, b=0x5A, Bin=0 → D=0x00, Bout=0.
  - a=0x10, b=0x01, Bin=1 → D=0x0E, Bout=0.
- Reset mid-stream: stream 4 back-to-back WIDTH=8 operations and assert rst_n=0 on the 3rd edge. Expect D=0, Bout=0, out_valid=0 the cycle after. Release, and the next accepted operation appears with 1-cycle latency.
- Random: 1000 random WIDTH=8 vectors with random in_valid. Compare against the model (a − b − Bin) mod 256 and borrow = (a < b + Bin), delayed one cycle, only where out_valid=1.
